// File: rtl/extender_pipe_r1.sv
// extender_pipe_r1
// Multi-lane, multi-mode immediate extender followed by a STAGES-deep
// valid/ready register pipeline. Sits between instruction decode and the
// operand-select muxes.
//
// Extension modes (sampled per transfer, applied to every lane):
//   0 zero-extend, 1 sign-extend, 2 upper placement (lane << OUT-IN),
//   3 sign-extend then shift left SHIFT, with per-lane overflow flag.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   en_n       active-low global enable; high freezes every register
//   flush      synchronous clear of all stage valids (priority over load)
//   in_valid   / in_ready   upstream handshake
//   mode       extension mode for this transfer
//   dataIn     DEPTH packed lanes of IN_WIDTH bits
//   out_valid  / out_ready  downstream handshake
//   dataOut    DEPTH packed lanes of OUT_WIDTH bits
//   ovf        per-lane overflow for mode 3, 0 otherwise
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Once out_valid is high, dataOut/ovf stay stable until the
// transfer completes. ready is combinational back through the stages, so a
// full pipeline accepts and emits in the same cycle when out_ready is high.
module extender_pipe_r1 #(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 32,
  parameter int DEPTH     = 1,
  parameter int STAGES    = 1,
  parameter int SHIFT     = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en_n,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [1:0]                   mode,
  input  logic [DEPTH*IN_WIDTH-1:0]    dataIn,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DEPTH*OUT_WIDTH-1:0]   dataOut,
  output logic [DEPTH-1:0]             ovf
);

  localparam int EXT_W = OUT_WIDTH + SHIFT;
  localparam int PAD_W = OUT_WIDTH - IN_WIDTH;

  logic [DEPTH*OUT_WIDTH-1:0] ext_data;
  logic [DEPTH-1:0]           ext_ovf;

  // Combinational extension ahead of stage 0.
  always_comb begin
    logic [IN_WIDTH-1:0] lane;
    logic [EXT_W-1:0]    sext;
    logic [EXT_W-1:0]    s;
    ext_data = '0;
    ext_ovf  = '0;
    lane     = '0;
    sext     = '0;
    s        = '0;
    for (int i = 0; i < DEPTH; i++) begin
      lane = dataIn[i*IN_WIDTH +: IN_WIDTH];
      sext = {{(EXT_W-IN_WIDTH){lane[IN_WIDTH-1]}}, lane};
      s    = sext << SHIFT;
      case (mode)
        2'd0: ext_data[i*OUT_WIDTH +: OUT_WIDTH] = {{PAD_W{1'b0}}, lane};
        2'd1: ext_data[i*OUT_WIDTH +: OUT_WIDTH] = sext[OUT_WIDTH-1:0];
        2'd2: ext_data[i*OUT_WIDTH +: OUT_WIDTH] = {lane, {PAD_W{1'b0}}};
        default: begin
          ext_data[i*OUT_WIDTH +: OUT_WIDTH] = s[OUT_WIDTH-1:0];
          // Overflow when any bit shifted past the output MSB disagrees
          // with the retained sign bit. Empty loop when SHIFT is 0.
          for (int j = OUT_WIDTH; j < EXT_W; j++) begin
            if (s[j] != s[OUT_WIDTH-1]) ext_ovf[i] = 1'b1;
          end
        end
      endcase
    end
  end

  logic [STAGES-1:0]          v;
  logic [STAGES-1:0]          rdy;
  logic [DEPTH*OUT_WIDTH-1:0] data_q [STAGES];
  logic [DEPTH-1:0]           ovf_q  [STAGES];

  // rdy[k] = ~v[k] | rdy[k+1], with out_ready beyond the last stage;
  // unrolled as a running OR to keep it a plain combinational chain.
  always_comb begin
    logic acc;
    acc = out_ready;
    rdy = '0;
    for (int k = STAGES-1; k >= 0; k--) begin
      acc    = acc | ~v[k];
      rdy[k] = acc;
    end
  end

  assign in_ready = ~en_n & ~flush & rdy[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v <= '0;
      for (int k = 0; k < STAGES; k++) begin
        data_q[k] <= '0;
        ovf_q[k]  <= '0;
      end
    end else if (!en_n) begin
      if (flush) begin
        v <= '0;
      end else begin
        if (rdy[0]) begin
          v[0] <= in_valid;
          if (in_valid) begin
            data_q[0] <= ext_data;
            ovf_q[0]  <= ext_ovf;
          end
        end
        for (int k = 1; k < STAGES; k++) begin
          if (rdy[k]) begin
            v[k] <= v[k-1];
            if (v[k-1]) begin
              data_q[k] <= data_q[k-1];
              ovf_q[k]  <= ovf_q[k-1];
            end
          end
        end
      end
    end
  end

  assign out_valid = v[STAGES-1];
  assign dataOut   = data_q[STAGES-1];
  assign ovf       = ovf_q[STAGES-1];

endmodule

// File: doc/extender_pipe_r1.md
# extender_pipe_r1

Pipelined, multi-lane, multi-mode immediate extender: the successor to the single-mode combinational sign extender. It takes DEPTH packed immediates per transfer and applies one of four extension modes: zero, sign, upper-placement (LUI-style), or sign-extend-and-shift (branch offset). It reports per-lane shift overflow and passes results through a STAGES-deep valid/ready pipeline with stall, global freeze and flush. It sits between instruction decode and the operand-select muxes.

## Interface
- IN_WIDTH, 16, width of one input lane; ≥1
- OUT_WIDTH, 32, width of one output lane; must be ≥ IN_WIDTH+1
- DEPTH, 1, number of lanes per transfer; ≥1
- STAGES, 1, number of register stages (latency); ≥1
- SHIFT, 2, left-shift amount for mode 3; 0 ≤ SHIFT < OUT_WIDTH

- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- en_n  in  1  active-low global enable; high freezes all state
- flush  in  1  synchronous clear of all pipeline valids
- in_valid  in  1  input transfer valid
- in_ready  out  1  block accepts input this cycle
- mode  in  2  0 zero-ext, 1 sign-ext, 2 upper, 3 sign-ext then shift-left SHIFT
- dataIn  in  DEPTH*IN_WIDTH  lane i at [i*IN_WIDTH +: IN_WIDTH]
- out_valid  out  1  output transfer valid
- out_ready  in  1  downstream accepts output
- dataOut  out  DEPTH*OUT_WIDTH  lane i at [i*OUT_WIDTH +: OUT_WIDTH]
- ovf  out  DEPTH  per-lane overflow flag for mode 3; 0 in other modes

## Operation
- Extension is combinational ahead of stage 0; stages 1..STAGES-1 carry data/ovf unchanged.
- Mode 0: upper OUT_WIDTH-IN_WIDTH bits zero, low bits = lane.
- Mode 1: upper bits replicate lane MSB.
- Mode 2: out = lane << (OUT_WIDTH-IN_WIDTH); low bits zero.
- Mode 3: s = sign-extend(lane) to OUT_WIDTH+SHIFT bits, shifted left SHIFT; out = s[OUT_WIDTH-1:0]; ovf = 1 iff any of s[OUT_WIDTH+SHIFT-1:OUT_WIDTH] differs from s[OUT_WIDTH-1]. SHIFT=0 gives ovf=0 and output equal to mode 1.
- Mode is sampled per transfer and applies to all lanes.
- Pipeline: each stage k has valid v[k]. ready[STAGES]=out_ready; ready[k] = ~v[k] | ready[k+1]. in_ready = ~en_n & ready[0]. Stage k loads from stage k-1 (or input) when ready[k]. It clears v[k] when ready[k] and the upstream stage is empty.
- out_valid = v[STAGES-1]; dataOut/ovf driven from the last stage register.
- en_n=1: no register changes, in_ready=0, out_valid holds its value, and no transfer completes. A stalled output is held stable.
- flush=1 with en_n=0: all v[k] ← 0 next edge, input is not accepted that cycle (in_ready=0), data registers are don't-care. flush has priority over load.
- en_n=1 overrides flush.

## Timing
- Reset (async assert, sync-safe deassert): all v[k]=0, all data and ovf registers 0. Hence out_valid=0, dataOut=0, ovf=0, in_ready=1 once rst falls (if en_n=0).
- Latency: an accepted input appears at out_valid exactly STAGES cycles later with no stall.
- Throughput: 1 transfer/cycle while out_ready=1.
- Full pipeline with out_ready=0: in_ready=0 the same cycle (combinational ready chain). Simultaneous out_ready=1 and in_valid=1 on a full pipeline accepts input and emits output in the same cycle, with no bubble.
- Output data stable while out_valid=1 & out_ready=0.
- Reset mid-operation discards all in-flight data immediately.

## Test plan
- Default params, mode 1, dataIn=0x8001 -> after 1 cycle out_valid=1, dataOut=0xFFFF8001, ovf=0. Mode 0 same input -> 0x00008001. Mode 2 -> 0x80010000. Mode 3 -> 0xFFFE0004, ovf=0.
- IN=8, OUT=9, SHIFT=2, mode 3: dataIn=0x40 -> dataOut=0x100, ovf=1. dataIn=0x10 -> 0x040, ovf=0. dataIn=0xF0 -> 0x1C0, ovf=0.
- DEPTH=2, STAGES=3: stream 10 transfers with out_ready=1 -> first out_valid 3 cycles after first accept, then 10 consecutive outputs in order, with lanes independently extended.
- STAGES=3, out_ready=0 for 6 cycles with in_valid=1 -> exactly 3 accepted, in_ready=0 afterwards, dataOut held. Raise out_ready -> the same-cycle accept/emit continues with no bubble.
- en_n=1 for 4 cycles mid-stream -> in_ready=0, all outputs frozen. flush=1 for one cycle -> out_valid=0 next cycle and no stale data emitted.
- Assert rst asynchronously between clock edges with the pipeline full -> out_valid, dataOut and ovf go 0 immediately. After release, the first accepted input emerges after STAGES cycles.
